fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 52 +++++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decoder.
// Signal names keep their direction suffixes as seen from the fetch unit.
// With FETCH_MISALIGN_EXC_EN defined the bundle also carries the
// misaligned-fetch exception outputs.
interface fetch_unit_if;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef FETCH_MISALIGN_EXC_EN
  logic        fetch_exc_o;
  logic [31:0] fetch_exc_pc_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output instr_valid_o, instr_o, pc_o, pc_plus4_o,
    input  instr_ready_i, redirect_i, redirect_pc_i,
    output fetch_exc_o, fetch_exc_pc_o
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  instr_valid_o, instr_o, pc_o, pc_plus4_o,
    output instr_ready_i, redirect_i, redirect_pc_i,
    input  fetch_exc_o, fetch_exc_pc_o
  );
`else
  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output instr_valid_o, instr_o, pc_o, pc_plus4_o,
    input  instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  instr_valid_o, instr_o, pc_o, pc_plus4_o,
    output instr_ready_i, redirect_i, redirect_pc_i
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// in-order instruction buffer toward decode, and redirect/flush handling.
// Optional feature macro: FETCH_MISALIGN_EXC_EN (misaligned redirect raises
// an exception and parks fetch in HALT until an aligned redirect).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(BUF_DEPTH);

`ifdef FETCH_MISALIGN_EXC_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t        state, state_next;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] cnt_out, cnt_buf, discard_cnt;
  logic [CW-1:0] cnt_out_next;
  logic [CW:0]   credit_used;
  logic [PW-1:0] head, tail;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];

  logic        req_valid, req_fire, rsp, push, pop, head_valid, misaligned;
  logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_EXC_EN
  logic        exc;
  logic [31:0] exc_pc;
  assign misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^bus.redirect_pc_i[1:0];
  assign misaligned = 1'b0;
`endif

  // Handshake decode and counter arithmetic shared by the sequential blocks.
  always_comb begin
    redir_pc     = {bus.redirect_pc_i[31:2], 2'b00};
    head_valid   = (cnt_buf != {CW{1'b0}});
    req_fire     = req_valid && bus.imem_req_ready_i;
    rsp          = bus.imem_rsp_valid_i;
    pop          = head_valid && bus.instr_ready_i;
    // A response during a redirect or while stale work is pending is dropped.
    push         = rsp && !bus.redirect_i && (discard_cnt == {CW{1'b0}});
    credit_used  = {1'b0, cnt_out} + {1'b0, cnt_buf};
    cnt_out_next = cnt_out + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, rsp};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_next;
  end

  // FSM next state: leave BOOT after one cycle; redirects pick RUN or HALT.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
`ifdef FETCH_MISALIGN_EXC_EN
      HALT:    state_next = HALT;
`endif
      default: state_next = BOOT;
    endcase
`ifdef FETCH_MISALIGN_EXC_EN
    if (bus.redirect_i) begin
      if (misaligned) state_next = HALT;
      else            state_next = RUN;
    end else begin
      state_next = state_next;
    end
`endif
  end

  // FSM outputs: request only in RUN and only while a buffer slot is reserved.
  always_comb begin
    req_valid = 1'b0;
    if (state == RUN && credit_used < DEPTH_C) req_valid = 1'b1;
    else                                       req_valid = 1'b0;
  end

  // PCs, credit/discard counters and buffer pointers; redirect wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      cnt_out     <= {CW{1'b0}};
      cnt_buf     <= {CW{1'b0}};
      discard_cnt <= {CW{1'b0}};
      head        <= {PW{1'b0}};
      tail        <= {PW{1'b0}};
    end else begin
      cnt_out <= cnt_out_next;
      if (bus.redirect_i) begin
        fetch_pc    <= redir_pc;
        rsp_pc      <= redir_pc;
        // Every request still in flight after this edge returns stale data.
        discard_cnt <= cnt_out_next;
        cnt_buf     <= {CW{1'b0}};
        head        <= {PW{1'b0}};
        tail        <= {PW{1'b0}};
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     rsp_pc   <= rsp_pc + 32'd4;
        if (rsp && discard_cnt != {CW{1'b0}}) discard_cnt <= discard_cnt - CNT_ONE;
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        cnt_buf <= cnt_buf + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
    end
  end

  // Buffer storage; contents are only observed when the entry is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail] <= bus.imem_rsp_data_i;
      buf_pc[tail]    <= rsp_pc;
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  // Exception flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc    <= 1'b0;
      exc_pc <= 32'h0000_0000;
    end else if (bus.redirect_i) begin
      exc <= misaligned;
      if (misaligned) exc_pc <= bus.redirect_pc_i;
    end
  end

  assign bus.fetch_exc_o    = exc;
  assign bus.fetch_exc_pc_o = exc_pc;
`endif

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = req_valid  ? fetch_pc : 32'h0000_0000;
  assign bus.instr_valid_o    = head_valid;
  assign bus.instr_o          = head_valid ? buf_instr[head] : 32'h0000_0000;
  assign bus.pc_o             = head_valid ? buf_pc[head] : 32'h0000_0000;
  assign bus.pc_plus4_o       = head_valid ? buf_pc[head] + 32'd4 : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a table of per-cycle vectors after
// reset plus hand-written sequences for back-pressure, stalls, redirect,
// PC wrap and (if FETCH_MISALIGN_EXC_EN) the misaligned-redirect exception.
// Memory model returns addr ^ 32'hA5A5_0000 after a programmable latency.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic        instr_ready;
    logic        req_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic [31:0] exp_instr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc, lat, n_req;
  pend_t       pend[$];
  logic [31:0] dlog[$];
  logic [31:0] p4log[$];
  logic [31:0] exp_req, exp_dpc, prev_addr;
  logic        prev_stall, prev_redir;
  vec_t        vecs[6];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Observe the cycle at the falling edge: request protocol and delivery scoreboard.
  task automatic monitor();
    if (prev_stall && !prev_redir) begin
      check32("req_hold_valid", {31'd0, bus.imem_req_valid_o}, 32'd1);
      check32("req_hold_addr", bus.imem_req_addr_o, prev_addr);
    end
    if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
      check32("req_addr_seq", bus.imem_req_addr_o, exp_req);
      exp_req = exp_req + 32'd4;
      pend.push_back('{bus.imem_req_addr_o, cyc + lat});
      n_req++;
    end
    prev_stall = bus.imem_req_valid_o && !bus.imem_req_ready_i;
    prev_addr  = bus.imem_req_addr_o;
    prev_redir = bus.redirect_i;
    if (bus.instr_valid_o && bus.instr_ready_i) begin
      check32("deliver_pc", bus.pc_o, exp_dpc);
      check32("deliver_instr", bus.instr_o, exp_dpc ^ 32'hA5A5_0000);
      check32("deliver_pc4", bus.pc_plus4_o, exp_dpc + 32'd4);
      exp_dpc = exp_dpc + 32'd4;
      dlog.push_back(bus.pc_o);
      p4log.push_back(bus.pc_plus4_o);
    end
    if (bus.redirect_i) begin
      exp_req = bus.redirect_pc_i & 32'hFFFF_FFFC;
      exp_dpc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      dlog.delete();
      p4log.delete();
    end
  endtask

  // Advance past the rising edge and drive the next memory response.
  task automatic step();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = pend[0].addr ^ 32'hA5A5_0000;
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = 32'h0000_0000;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0000_0000;
    bus.instr_ready_i = 1'b0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i = 32'h0000_0000;
    pend.delete();
    dlog.delete();
    p4log.delete();
    prev_stall = 1'b0;
    prev_redir = 1'b0;
    exp_req = 32'h0000_0000;
    exp_dpc = 32'h0000_0000;
    n_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd0);
    check32("rst_req_addr", bus.imem_req_addr_o, 32'd0);
    check32("rst_instr_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check32("rst_instr", bus.instr_o, 32'd0);
    check32("rst_pc", bus.pc_o, 32'd0);
    check32("rst_pc4", bus.pc_plus4_o, 32'd0);
`ifdef FETCH_MISALIGN_EXC_EN
    check32("rst_exc", {31'd0, bus.fetch_exc_o}, 32'd0);
    check32("rst_exc_pc", bus.fetch_exc_pc_o, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_deliveries(input int n, input int budget);
    for (int i = 0; i < budget && dlog.size() < n; i++) tick();
  endtask

  initial begin
    int n0;
    lat = 1;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 32'h4, 32'hA5A5_0000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 32'h8, 32'hA5A5_0004};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'hC, 32'hA5A5_0008};

    // Reset release and one instruction per cycle with 1-cycle memory.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.instr_ready_i    = vecs[i].instr_ready;
      bus.imem_req_ready_i = vecs[i].req_ready;
      @(negedge clk);
      check32($sformatf("v%0d_req_valid", i), {31'd0, bus.imem_req_valid_o}, {31'd0, vecs[i].exp_req_valid});
      check32($sformatf("v%0d_req_addr", i), bus.imem_req_addr_o, vecs[i].exp_req_addr);
      check32($sformatf("v%0d_instr_valid", i), {31'd0, bus.instr_valid_o}, {31'd0, vecs[i].exp_iv});
      check32($sformatf("v%0d_pc", i), bus.pc_o, vecs[i].exp_pc);
      check32($sformatf("v%0d_pc4", i), bus.pc_plus4_o, vecs[i].exp_p4);
      check32($sformatf("v%0d_instr", i), bus.instr_o, vecs[i].exp_instr);
      step();
    end

    // Decoder stalled: exactly BUF_DEPTH requests, then drain in order.
    do_reset();
    bus.instr_ready_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    repeat (12) tick();
    check32("stall_req_count", n_req, 32'd4);
    @(negedge clk);
    check32("stall_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd0);
    check32("stall_instr_valid", {31'd0, bus.instr_valid_o}, 32'd1);
    check32("stall_head_pc", bus.pc_o, 32'd0);
    step();
    bus.instr_ready_i = 1'b1;
    wait_deliveries(8, 40);
    check32("drain_count", {31'd0, dlog.size() >= 8}, 32'd1);
    check32("drain_pc3", qget(dlog, 3), 32'hC);
    check32("drain_pc4", qget(dlog, 4), 32'h10);

    // Memory accepts one request in three.
    do_reset();
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.imem_req_ready_i = (i % 3 == 2);
      tick();
    end
    check32("toggle_req_count", {31'd0, n_req >= 8}, 32'd1);
    check32("toggle_deliveries", {31'd0, dlog.size() >= 7}, 32'd1);

    // Three requests in flight with 3-cycle memory, then redirect to 0x100.
    do_reset();
    lat = 3;
    bus.instr_ready_i = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    for (int i = 0; i < 20 && n_req < 3; i++) tick();
    check32("redir_inflight", n_req, 32'd3);
    bus.imem_req_ready_i = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0100;
    tick();
    bus.redirect_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    @(negedge clk);
    check32("redir_instr_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check32("redir_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd1);
    check32("redir_req_addr", bus.imem_req_addr_o, 32'h100);
    step();
    wait_deliveries(2, 40);
    check32("redir_first_pc", qget(dlog, 0), 32'h100);
    check32("redir_second_pc", qget(dlog, 1), 32'h104);

    // PC wrap at the top of the address space.
    do_reset();
    lat = 1;
    bus.instr_ready_i = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    bus.redirect_i = 1'b0;
    wait_deliveries(3, 40);
    check32("wrap_pc0", qget(dlog, 0), 32'hFFFF_FFF8);
    check32("wrap_pc1", qget(dlog, 1), 32'hFFFF_FFFC);
    check32("wrap_pc2", qget(dlog, 2), 32'h0000_0000);
    check32("wrap_pc4_of_last", qget(p4log, 1), 32'h0000_0000);

`ifdef FETCH_MISALIGN_EXC_EN
    // Misaligned redirect halts fetch; an aligned one resumes it.
    do_reset();
    bus.instr_ready_i = 1'b1;
    bus.imem_req_ready_i = 1'b1;
    repeat (3) tick();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0102;
    tick();
    bus.redirect_i = 1'b0;
    @(negedge clk);
    check32("exc_set", {31'd0, bus.fetch_exc_o}, 32'd1);
    check32("exc_pc", bus.fetch_exc_pc_o, 32'h102);
    check32("exc_instr_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    step();
    n0 = n_req;
    repeat (5) tick();
    check32("halt_no_req", n_req, n0);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    tick();
    bus.redirect_i = 1'b0;
    @(negedge clk);
    check32("exc_clear", {31'd0, bus.fetch_exc_o}, 32'd0);
    step();
    wait_deliveries(1, 40);
    check32("resume_pc", qget(dlog, 0), 32'h200);
`else
    n0 = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
